// File: rtl/msrh_l1d_rd_arbiter_pkg.sv
// Shared types and defaults for the L1D read-port arbiter.
// The s1 status encoding matches the LSU STATUS_* codes so callers can
// fold the arbiter's per-requester s1 flags straight into their replay logic.
package msrh_l1d_rd_arbiter_pkg;

    // Default widths used when the arbiter is built standalone.
    localparam int L1D_PADDR_W = 56;
    localparam int L1D_DATA_W  = 128;

    typedef enum logic [1:0] {
        STATUS_NONE     = 2'd0,
        STATUS_HIT      = 2'd1,
        STATUS_MISS     = 2'd2,
        STATUS_CONFLICT = 2'd3
    } l1d_rd_arb_status_t;

    // Collapse one requester's s1 flags into a single status code.
    function automatic l1d_rd_arb_status_t l1d_rd_arb_status(input logic hit,
                                                             input logic miss,
                                                             input logic conflict);
        if (conflict)  return STATUS_CONFLICT;
        else if (hit)  return STATUS_HIT;
        else if (miss) return STATUS_MISS;
        else           return STATUS_NONE;
    endfunction

endpackage

// File: rtl/msrh_l1d_rr_picker.sv
// Combinational round-robin one-hot picker: searches upward from i_ptr with
// wrap and returns the first requesting index as a one-hot grant.
// The pointer is expected to stay below N.
module msrh_l1d_rr_picker #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    int   idx;
    logic found;

    // Scan N positions starting at the pointer; first requester wins.
    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msrh_l1d_rd_arbiter.sv
// L1D read-port arbiter: grants one of REQ_NUM requesters per cycle in s0
// and steers the dcache s1 response back (hit/miss to the winner, conflict
// to every loser). Priority: starved > h_pri (lowest index) > round-robin.
// Optional starvation guard: define MSRH_L1D_ARB_STARVE_GUARD_EN.
module msrh_l1d_rd_arbiter
    import msrh_l1d_rd_arbiter_pkg::*;
#(
    parameter int REQ_NUM   = 5,
    parameter int PADDR_W   = L1D_PADDR_W,
    parameter int DATA_W    = L1D_DATA_W,
    parameter int STARVE_TH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [REQ_NUM-1:0]               i_req_valid,
    input  logic [REQ_NUM-1:0]               i_req_h_pri,
    input  logic [REQ_NUM-1:0][PADDR_W-1:0]  i_req_paddr,
    output logic [REQ_NUM-1:0]               o_req_grant,
    output logic                             o_dc_s0_valid,
    output logic [PADDR_W-1:0]               o_dc_s0_paddr,
    input  logic                             i_dc_s1_hit,
    input  logic                             i_dc_s1_miss,
    input  logic [DATA_W-1:0]                i_dc_s1_data,
    output logic [REQ_NUM-1:0]               o_resp_s1_valid,
    output logic [REQ_NUM-1:0]               o_resp_s1_hit,
    output logic [REQ_NUM-1:0]               o_resp_s1_miss,
    output logic [REQ_NUM-1:0]               o_resp_s1_conflict,
    output logic [DATA_W-1:0]                o_resp_s1_data
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   rr_next_ptr;
    logic [REQ_NUM-1:0] r_s1_req;
    logic [REQ_NUM-1:0] r_s1_grant;
    logic [REQ_NUM-1:0] hpri_req;
    logic [REQ_NUM-1:0] starved;
    logic [REQ_NUM-1:0] rr_grant;
    logic [REQ_NUM-1:0] grant;
    logic               rr_win;

    assign hpri_req = i_req_valid & i_req_h_pri;

`ifdef MSRH_L1D_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_TH + 1);

    logic [REQ_NUM-1:0][CNT_W-1:0] r_starve_cnt;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_starve
        // Count consecutive losses; saturate at the threshold, clear on win or idle.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n)
                r_starve_cnt[g] <= '0;
            else if (!i_req_valid[g] || grant[g])
                r_starve_cnt[g] <= '0;
            else if (r_starve_cnt[g] != CNT_W'(STARVE_TH))
                r_starve_cnt[g] <= r_starve_cnt[g] + 1'b1;
        end
        assign starved[g] = i_req_valid[g] && (r_starve_cnt[g] == CNT_W'(STARVE_TH));
    end
`else
    // Threshold only matters when the guard is built in.
    logic unused_starve_th;
    assign unused_starve_th = ^STARVE_TH;
    assign starved          = '0;
`endif

    msrh_l1d_rr_picker #(
        .N     (REQ_NUM),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (rr_grant)
    );

    // Winner select: starved, then h_pri, then round-robin; x & -x isolates lowest bit.
    always_comb begin
        grant  = '0;
        rr_win = 1'b0;
        if (|starved)
            grant = starved & (~starved + REQ_NUM'(1));
        else if (|hpri_req)
            grant = hpri_req & (~hpri_req + REQ_NUM'(1));
        else begin
            grant  = rr_grant;
            rr_win = |rr_grant;
        end
    end

    // Pointer moves just past a round-robin winner, wrapping to 0.
    always_comb begin
        rr_next_ptr = r_rr_ptr;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (rr_grant[i])
                rr_next_ptr = (i == REQ_NUM - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    // Round-robin pointer only advances on a round-robin win.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_rr_ptr <= '0;
        else if (rr_win)
            r_rr_ptr <= rr_next_ptr;
    end

    // Granted paddr onto the dcache port; zero when nothing is granted.
    always_comb begin
        o_dc_s0_paddr = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant[i]) o_dc_s0_paddr = o_dc_s0_paddr | i_req_paddr[i];
        end
    end

    // s1 stage: remember who asked and who won; reset drops the pending response.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_req   <= '0;
            r_s1_grant <= '0;
        end else begin
            r_s1_req   <= i_req_valid;
            r_s1_grant <= grant;
        end
    end

    assign o_req_grant        = grant;
    assign o_dc_s0_valid      = |grant;
    assign o_resp_s1_valid    = r_s1_req;
    assign o_resp_s1_hit      = r_s1_grant & {REQ_NUM{i_dc_s1_hit}};
    assign o_resp_s1_miss     = r_s1_grant & {REQ_NUM{i_dc_s1_miss}};
    assign o_resp_s1_conflict = r_s1_req & ~r_s1_grant;
    assign o_resp_s1_data     = i_dc_s1_data;

`ifdef SIMULATION
    // The dcache never reports hit and miss for the same access.
    always @(posedge i_clk) begin
        if (i_reset_n)
            assert (!(i_dc_s1_hit && i_dc_s1_miss))
                else $fatal(1, "l1d_rd_arbiter: dcache s1 hit and miss both high");
    end
`endif

endmodule

// File: doc/msrh_l1d_rd_arbiter.md
# msrh_l1d_rd_arbiter

Arbitrates REQ_NUM L1D read requesters (snoop, PTW, LRQ, ST-buffer, LSU pipes) onto one physical dcache read port in the LSU top. It grants one request per cycle in s0 and steers the s1 hit/miss/data response back to the winner. Every loser receives an s1 conflict so its owner can replay. Arbitration uses fixed priority among high-priority requests and round-robin among normal ones, with an optional starvation guard.

## Interface
Parameters:
- REQ_NUM, 5, number of requesters; must be ≥2.
- PADDR_W, riscv_pkg::PADDR_W, physical address width.
- DATA_W, msrh_conf_pkg::DCACHE_DATA_W, dcache line read width.
- STARVE_TH, 8, consecutive losses before promotion; only used under the starvation macro.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  REQ_NUM  s0 request valid, one bit per requester.
- i_req_h_pri  in  REQ_NUM  s0 high-priority flag; ignored when the matching valid is low.
- i_req_paddr  in  REQ_NUM×PADDR_W  s0 physical address per requester.
- o_req_grant  out  REQ_NUM  s0 one-hot grant, combinational.
- o_dc_s0_valid  out  1  dcache port s0 valid; equals |o_req_grant.
- o_dc_s0_paddr  out  PADDR_W  paddr of the granted requester; 0 when there is no grant.
- i_dc_s1_hit  in  1  dcache s1 hit.
- i_dc_s1_miss  in  1  dcache s1 miss.
- i_dc_s1_data  in  DATA_W  dcache s1 data.
- o_resp_s1_valid  out  REQ_NUM  per requester: it requested in the previous cycle.
- o_resp_s1_hit  out  REQ_NUM  hit, winner only.
- o_resp_s1_miss  out  REQ_NUM  miss, winner only.
- o_resp_s1_conflict  out  REQ_NUM  set for every loser of the previous cycle.
- o_resp_s1_data  out  DATA_W  broadcast copy of i_dc_s1_data; meaningful only with the winner's hit.

## Operation
- Winner selection, in priority order:
  1. Starved requesters (macro only), lowest index wins.
  2. Valid requesters with h_pri set, lowest index wins.
  3. Normal requesters, round-robin starting at r_rr_ptr and searching upward with wrap.
- Round-robin pointer:
  - r_rr_ptr is $clog2(REQ_NUM) bits.
  - After a grant won in step 3: r_rr_ptr ← (winner+1), wrapping REQ_NUM−1 → 0.
  - After a step 1 or step 2 win, or with no request: unchanged.
- s1 registers, loaded every cycle:
  - r_s1_req ← i_req_valid.
  - r_s1_grant ← o_req_grant.
- s1 outputs:
  - o_resp_s1_valid = r_s1_req.
  - o_resp_s1_hit[i] = r_s1_grant[i] & i_dc_s1_hit.
  - o_resp_s1_miss[i] = r_s1_grant[i] & i_dc_s1_miss.
  - o_resp_s1_conflict[i] = r_s1_req[i] & ~r_s1_grant[i].
- Exactly one winner whenever any valid is high. No request is held internally; a loser must re-request.

## Timing
- s0 grant has zero latency. The response arrives exactly one cycle later (s1).
- Back-to-back grants to the same requester are allowed.
- All REQ_NUM requesting at once: exactly one grant, REQ_NUM−1 conflicts in s1.
- Reset values:
  - r_rr_ptr=0, r_s1_req=0, r_s1_grant=0, starvation counters=0.
  - Therefore all o_resp_* are 0, and o_req_grant/o_dc_s0_* are 0 while inputs are idle.
- Reset asserted mid-transaction: the pending s1 response is dropped (valid=0). Requesters must treat that as a flush.
- Both i_dc_s1_hit and i_dc_s1_miss high is illegal; assert under SIMULATION with $fatal.

## Configuration
- MSRH_L1D_ARB_STARVE_GUARD_EN defined:
  - Each requester has a saturating counter of width $clog2(STARVE_TH+1).
  - It increments when the requester is valid but not granted.
  - It clears when the requester is granted or its valid is low.
  - counter==STARVE_TH marks the requester starved, which puts it in step 1.
- Undefined: no counters, step 1 is absent, and a normal requester may lose indefinitely to h_pri traffic.

## Structure
- msrh_lsu_pkg: add typedef l1d_rd_arb_status_t (HIT/MISS/CONFLICT/NONE), mirroring the existing STATUS_* encoding so callers map s1 outputs directly.
- One sub-module, msrh_l1d_rr_picker: a parameterised combinational round-robin one-hot picker (req vector, pointer in; grant one-hot out). It is reusable by msrh_l2_req_arbiter.
- Counters, pointer and s1 registers live in the top of this block.

## Test plan
1. After reset, req_valid=5'b00110 with no h_pri, held 3 cycles → grants 00010, 00100, 00010; r_rr_ptr goes 0→2→3→2. The loser sees s1 conflict each cycle.
2. req_valid=5'b11111, h_pri=5'b01000 → grant=01000 and dc paddr=paddr[3]. Next cycle conflict=10111; with i_dc_s1_hit=1, hit=01000.
3. req 0 only at cycle 0 with i_dc_s1_miss=1 at cycle 1 → resp_valid=00001, miss=00001, hit=0, conflict=0.
4. Macro on, STARVE_TH=8: req 4 normal, req 0 h_pri continuous → req 0 wins 8 cycles, then req 4 wins on cycle 9 and its counter clears. With the macro off, req 4 never wins.
5. Grant on cycle N, i_reset_n low at N+0.5 → every o_resp_* is 0 in cycle N+1 and r_rr_ptr=0.
6. No requests for 4 cycles → o_dc_s0_valid=0, o_dc_s0_paddr=0, all resp outputs 0, pointer unchanged.
